// File: rtl/video_timing_pkg.sv
// Shared constants and types for the pixel-clock display timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_timing_pkg;

  // 640x480@60 defaults
  localparam int COORDSPC_DEF = 16;
  localparam int H_RES_DEF    = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_RES_DEF    = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic {
    HOLD,
    RUN
  } timing_state_t;

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: signed wrapping counter STA..RES-1 plus look-ahead window flags.
// Latency: pos updates one cycle after adv; sync_nxt/act_nxt describe the value pos takes next.
// Backpressure: none; advances whenever adv is high and hold is low.
module video_timing_axis #(
  parameter int W        = 16,
  parameter int STA      = -160,
  parameter int RES      = 640,
  parameter int SYNC_BEG = -144,
  parameter int SYNC_END = -49
) (
  input  logic                video_clk_pix,
  input  logic                rst,
  input  logic                hold,
  input  logic                adv,
  output logic signed [W-1:0] pos,
  output logic                wrap,
  output logic                sync_nxt,
  output logic                act_nxt
);

  localparam logic signed [W-1:0] STA_V  = W'(STA);
  localparam logic signed [W-1:0] LAST_V = W'(RES - 1);
  localparam logic signed [W-1:0] SB_V   = W'(SYNC_BEG);
  localparam logic signed [W-1:0] SE_V   = W'(SYNC_END);
  localparam logic signed [W-1:0] ONE_V  = W'(1);

  logic signed [W-1:0] pos_nxt;

  // Next position and the flags the registered outputs will carry for it
  always_comb begin
    wrap    = (pos == LAST_V);
    pos_nxt = pos;
    if (hold) begin
      pos_nxt = STA_V;
    end else if (adv) begin
      pos_nxt = wrap ? STA_V : pos + ONE_V;
    end
    sync_nxt = (pos_nxt >= SB_V) && (pos_nxt <= SE_V);
    act_nxt  = !pos_nxt[W-1];
  end

  // Position register; reset parks the axis at its first blanking position
  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      pos <= STA_V;
    end else begin
      pos <= pos_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Display timing generator: signed sx/sy, sync pulses, active flag, frame/line strobes.
// Latency: all outputs registered together, zero skew; first frame pixel one edge after rst drops.
// Backpressure: none; free-running at one pixel per video_clk_pix.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int COORDSPC = COORDSPC_DEF,
  parameter int H_RES    = H_RES_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic                       video_clk_pix,
  input  logic                       rst,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       frame_start,
  output logic                       line_start,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy
);

  localparam int   H_STA = -(H_FP + H_SYNC + H_BP);
  localparam int   V_STA = -(V_FP + V_SYNC + V_BP);
  localparam logic H_ACT = 1'(H_POL);
  localparam logic V_ACT = 1'(V_POL);

  // Coordinates must fit the signed width on both ends of each axis
  if ((H_RES - 1 > 2**(COORDSPC-1) - 1) || (-H_STA > 2**(COORDSPC-1)) ||
      (V_RES - 1 > 2**(COORDSPC-1) - 1) || (-V_STA > 2**(COORDSPC-1))) begin : g_bad_width
    $error("video_timing_gen: timing does not fit in COORDSPC-bit signed coordinates");
  end

  timing_state_t state, state_nxt;
  logic hold;
  logic h_wrap, h_sync_nxt, h_act_nxt;
  logic v_wrap, v_sync_nxt, v_act_nxt;

  // State register: reset parks in HOLD
  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      state <= HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD lasts until the first edge without reset, which emits pixel (H_STA, V_STA)
  always_comb begin
    state_nxt = state;
    hold      = 1'b0;
    case (state)
      HOLD: begin
        hold      = 1'b1;
        state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = HOLD;
    endcase
  end

  video_timing_axis #(
    .W(COORDSPC), .STA(H_STA), .RES(H_RES),
    .SYNC_BEG(H_STA + H_FP), .SYNC_END(H_STA + H_FP + H_SYNC - 1)
  ) u_h_axis (
    .video_clk_pix(video_clk_pix),
    .rst          (rst),
    .hold         (hold),
    .adv          (1'b1),
    .pos          (sx),
    .wrap         (h_wrap),
    .sync_nxt     (h_sync_nxt),
    .act_nxt      (h_act_nxt)
  );

  video_timing_axis #(
    .W(COORDSPC), .STA(V_STA), .RES(V_RES),
    .SYNC_BEG(V_STA + V_FP), .SYNC_END(V_STA + V_FP + V_SYNC - 1)
  ) u_v_axis (
    .video_clk_pix(video_clk_pix),
    .rst          (rst),
    .hold         (hold),
    .adv          (h_wrap),
    .pos          (sy),
    .wrap         (v_wrap),
    .sync_nxt     (v_sync_nxt),
    .act_nxt      (v_act_nxt)
  );

  // Flags registered alongside sx/sy so they always describe the same pixel;
  // the next pixel is a line/frame origin exactly when leaving HOLD or wrapping
  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      hsync        <= ~H_ACT;
      vsync        <= ~V_ACT;
      video_enable <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      hsync        <= h_sync_nxt ? H_ACT : ~H_ACT;
      vsync        <= v_sync_nxt ? V_ACT : ~V_ACT;
      video_enable <= h_act_nxt && v_act_nxt;
      line_start   <= hold || h_wrap;
      frame_start  <= hold || (h_wrap && v_wrap);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance and a tiny active-high-sync instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_video_timing_gen;

  logic video_clk_pix = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic hsync_a, vsync_a, ve_a, fs_a, ls_a;
  logic signed [15:0] sx_a, sy_a;
  logic hsync_b, vsync_b, ve_b, fs_b, ls_b;
  logic signed [7:0] sx_b, sy_b;

  int n_checks = 0;
  int n_errors = 0;

  int ex, ey, pos_err, ls_cnt, last_ls, gap_err, fs_cnt, last_fs, fs_gap_err;
  int hs_len0, hs_first, hs_seen, ve_neg, ve_first, ve_cnt;
  int vs_cnt, vs_first_x, vs_first_y, vs_first_c, vs_seen;

  always #5 video_clk_pix = ~video_clk_pix;

  video_timing_gen u_dut_a (
    .video_clk_pix(video_clk_pix),
    .rst          (rst_a),
    .hsync        (hsync_a),
    .vsync        (vsync_a),
    .video_enable (ve_a),
    .frame_start  (fs_a),
    .line_start   (ls_a),
    .sx           (sx_a),
    .sy           (sy_a)
  );

  video_timing_gen #(
    .COORDSPC(8), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
  ) u_dut_b (
    .video_clk_pix(video_clk_pix),
    .rst          (rst_b),
    .hsync        (hsync_b),
    .vsync        (vsync_b),
    .video_enable (ve_b),
    .frame_start  (fs_b),
    .line_start   (ls_b),
    .sx           (sx_b),
    .sy           (sy_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // ---------------- reset hold, both instances ----------------
    @(negedge video_clk_pix);
    @(negedge video_clk_pix);
    check_eq("a_rst_sx", sx_a, -160);
    check_eq("a_rst_sy", sy_a, -45);
    check_eq("a_rst_hsync", hsync_a, 1);
    check_eq("a_rst_vsync", vsync_a, 1);
    check_eq("a_rst_ve", ve_a, 0);
    check_eq("a_rst_fs", fs_a, 0);
    check_eq("a_rst_ls", ls_a, 0);
    check_eq("b_rst_sx", sx_b, -6);
    check_eq("b_rst_sy", sy_b, -3);
    check_eq("b_rst_hsync", hsync_b, 0);
    check_eq("b_rst_vsync", vsync_b, 0);

    // ---------------- default instance: 47 lines ----------------
    rst_a = 1'b0;
    @(negedge video_clk_pix);
    check_eq("a_first_fs", fs_a, 1);
    check_eq("a_first_ls", ls_a, 1);
    check_eq("a_first_sx", sx_a, -160);
    check_eq("a_first_sy", sy_a, -45);

    ex = -160; ey = -45; pos_err = 0; ls_cnt = 0; last_ls = -1; gap_err = 0; fs_cnt = 0;
    hs_len0 = 0; hs_first = 0; hs_seen = 0; ve_neg = 0; ve_first = -1;
    vs_cnt = 0; vs_first_x = 0; vs_first_y = 0; vs_seen = 0;
    for (int c = 0; c < 47 * 800; c++) begin
      if (c != 0) @(negedge video_clk_pix);
      if (int'(sx_a) != ex || int'(sy_a) != ey) pos_err++;
      if (ls_a) begin
        ls_cnt++;
        if (last_ls >= 0 && c - last_ls != 800) gap_err++;
        last_ls = c;
      end
      if (fs_a) fs_cnt++;
      if (!hsync_a) begin
        if (c < 800) hs_len0++;
        if (hs_seen == 0) begin hs_first = sx_a; hs_seen = 1; end
      end
      if (ve_a && ey < 0) ve_neg++;
      if (ve_a && ve_first < 0) ve_first = c;
      if (!vsync_a) begin
        vs_cnt++;
        if (vs_seen == 0) begin vs_first_x = sx_a; vs_first_y = sy_a; vs_seen = 1; end
      end
      if (ex == 639) begin
        ex = -160;
        ey = (ey == 479) ? -45 : ey + 1;
      end else begin
        ex++;
      end
    end
    check_eq("a_pos_track_err", pos_err, 0);
    check_eq("a_ls_count", ls_cnt, 47);
    check_eq("a_ls_gap_err", gap_err, 0);
    check_eq("a_fs_count", fs_cnt, 1);
    check_eq("a_hsync_len", hs_len0, 96);
    check_eq("a_hsync_first_sx", hs_first, -144);
    check_eq("a_ve_in_vblank", ve_neg, 0);
    check_eq("a_ve_first_cycle", ve_first, 45 * 800 + 160);
    check_eq("a_vsync_len", vs_cnt, 1600);
    check_eq("a_vsync_first_sx", vs_first_x, -160);
    check_eq("a_vsync_first_sy", vs_first_y, -35);

    // B must still be parked while its reset is held
    check_eq("b_hold_sx", sx_b, -6);
    check_eq("b_hold_ls", ls_b, 0);

    // ---------------- small instance: 2 frames + into a third ----------------
    rst_b = 1'b0;
    @(negedge video_clk_pix);
    ex = -6; ey = -3; pos_err = 0; ls_cnt = 0; fs_cnt = 0; last_fs = -1; fs_gap_err = 0;
    ve_cnt = 0; hs_len0 = 0; hs_first = 0; hs_seen = 0;
    vs_cnt = 0; vs_first_x = 0; vs_first_c = -1; vs_seen = 0;
    for (int c = 0; c < 262; c++) begin
      if (c != 0) @(negedge video_clk_pix);
      if (int'(sx_b) != ex || int'(sy_b) != ey) pos_err++;
      if (ls_b) ls_cnt++;
      if (fs_b) begin
        fs_cnt++;
        if (last_fs >= 0 && c - last_fs != 98) fs_gap_err++;
        last_fs = c;
      end
      if (c < 98 && ve_b) ve_cnt++;
      if (c < 14 && hsync_b) hs_len0++;
      if (hsync_b && hs_seen == 0) begin hs_first = sx_b; hs_seen = 1; end
      if (c < 98 && vsync_b) begin
        vs_cnt++;
        if (vs_seen == 0) begin vs_first_c = c; vs_first_x = sx_b; vs_seen = 1; end
      end
      if (c == 0) begin
        check_eq("b_first_fs", fs_b, 1);
        check_eq("b_first_ls", ls_b, 1);
      end
      if (c == 97) begin
        check_eq("b_last_sx", sx_b, 7);
        check_eq("b_last_sy", sy_b, 3);
        check_eq("b_last_ve", ve_b, 1);
      end
      if (c == 98) begin
        check_eq("b_wrap_sx", sx_b, -6);
        check_eq("b_wrap_sy", sy_b, -3);
        check_eq("b_wrap_fs", fs_b, 1);
        check_eq("b_wrap_ls", ls_b, 1);
        check_eq("b_wrap_ve", ve_b, 0);
      end
      if (ex == 7) begin
        ex = -6;
        ey = (ey == 3) ? -3 : ey + 1;
      end else begin
        ex++;
      end
    end
    check_eq("b_pos_track_err", pos_err, 0);
    check_eq("b_ls_count", ls_cnt, 19);
    check_eq("b_fs_count", fs_cnt, 3);
    check_eq("b_fs_gap_err", fs_gap_err, 0);
    check_eq("b_ve_count", ve_cnt, 32);
    check_eq("b_hsync_len", hs_len0, 2);
    check_eq("b_hsync_first_sx", hs_first, -4);
    check_eq("b_vsync_len", vs_cnt, 14);
    check_eq("b_vsync_first_cycle", vs_first_c, 14);
    check_eq("b_vsync_first_sx", vs_first_x, -6);
    check_eq("b_mid_sx", sx_b, 3);
    check_eq("b_mid_sy", sy_b, 1);

    // ---------------- mid-frame asynchronous reset ----------------
    #2 rst_b = 1'b1;
    #1;
    check_eq("b_arst_sx", sx_b, -6);
    check_eq("b_arst_sy", sy_b, -3);
    check_eq("b_arst_ve", ve_b, 0);
    check_eq("b_arst_hsync", hsync_b, 0);
    check_eq("b_arst_vsync", vsync_b, 0);
    @(negedge video_clk_pix);
    rst_b = 1'b0;
    @(negedge video_clk_pix);
    check_eq("b_restart_fs", fs_b, 1);
    check_eq("b_restart_ls", ls_b, 1);
    check_eq("b_restart_sx", sx_b, -6);
    check_eq("b_restart_sy", sy_b, -3);
    @(negedge video_clk_pix);
    check_eq("b_restart_next_sx", sx_b, -5);
    check_eq("b_restart_next_fs", fs_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
